// File: rtl/zmem_arbiter.sv
// Arbitrates one external memory bus between video fetch, the Z80 memory strobe and DMA.
// Fixed priority video > CPU > DMA, with a starvation override that eventually forces DMA through.
module zmem_arbiter #(
    parameter int AW      = 20,
    parameter int DW      = 16,
    parameter int ACC_CYC = 4,
    parameter int STARVE  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_wait,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    input  logic          dma_req,
    input  logic          dma_rnw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LAST_CNT   = 4'(ACC_CYC - 1);
    localparam logic [3:0] WE_OFF_CNT = 4'(ACC_CYC - 2);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t        state, state_next;
    owner_t        owner, owner_next;
    owner_t        grant;
    logic [3:0]    cnt, cnt_next;
    logic [3:0]    starve_cnt, starve_next;
    logic          acc_rnw, acc_rnw_next;

    logic          cpu_pend, cpu_pend_next;
    logic          cpu_rnw_l, cpu_rnw_l_next;
    logic [AW-1:0] cpu_addr_l, cpu_addr_l_next;
    logic [DW-1:0] cpu_wdata_l, cpu_wdata_l_next;

    logic [AW-1:0] mem_addr_next;
    logic [DW-1:0] mem_wdata_next;
    logic          mem_oe_next, mem_we_next;
    logic [DW-1:0] cpu_rdata_next, vid_rdata_next, dma_rdata_next;
    logic          cpu_done_next, vid_ack_next, dma_ack_next;

    logic          last_edge, cpu_done_edge, cpu_any;
    logic          cpu_sel_rnw;
    logic [AW-1:0] cpu_sel_addr;
    logic [DW-1:0] cpu_sel_wdata;

    assign last_edge     = (state == ACCESS) && (cnt == LAST_CNT);
    assign cpu_done_edge = last_edge && (owner == OWN_CPU);

    // A strobe in the same cycle as the grant decision is served straight from the inputs.
    assign cpu_any       = cpu_pend | cpu_req;
    assign cpu_sel_rnw   = cpu_pend ? cpu_rnw_l   : cpu_rnw;
    assign cpu_sel_addr  = cpu_pend ? cpu_addr_l  : cpu_addr;
    assign cpu_sel_wdata = cpu_pend ? cpu_wdata_l : cpu_wdata;

    assign cpu_wait = cpu_req | cpu_pend;

    always_comb begin
        state_next       = state;
        owner_next       = owner;
        grant            = OWN_NONE;
        cnt_next         = cnt;
        starve_next      = starve_cnt;
        acc_rnw_next     = acc_rnw;
        cpu_pend_next    = cpu_pend;
        cpu_rnw_l_next   = cpu_rnw_l;
        cpu_addr_l_next  = cpu_addr_l;
        cpu_wdata_l_next = cpu_wdata_l;
        mem_addr_next    = mem_addr;
        mem_wdata_next   = mem_wdata;
        mem_oe_next      = mem_oe;
        mem_we_next      = mem_we;
        cpu_rdata_next   = cpu_rdata;
        vid_rdata_next   = vid_rdata;
        dma_rdata_next   = dma_rdata;
        cpu_done_next    = 1'b0;
        vid_ack_next     = 1'b0;
        dma_ack_next     = 1'b0;

        // The completion edge frees the pending slot, so a coinciding strobe re-arms it.
        if (cpu_req && (!cpu_pend || cpu_done_edge)) begin
            cpu_pend_next    = 1'b1;
            cpu_rnw_l_next   = cpu_rnw;
            cpu_addr_l_next  = cpu_addr;
            cpu_wdata_l_next = cpu_wdata;
        end else if (cpu_done_edge) begin
            cpu_pend_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (dma_req && (starve_cnt == STARVE_MAX)) begin
                    grant = OWN_DMA;
                end else if (vid_req) begin
                    grant = OWN_VID;
                end else if (cpu_any) begin
                    grant = OWN_CPU;
                end else if (dma_req) begin
                    grant = OWN_DMA;
                end

                case (grant)
                    OWN_VID: begin
                        mem_addr_next  = vid_addr;
                        mem_wdata_next = '0;
                        acc_rnw_next   = 1'b1;
                    end
                    OWN_CPU: begin
                        mem_addr_next  = cpu_sel_addr;
                        mem_wdata_next = cpu_sel_wdata;
                        acc_rnw_next   = cpu_sel_rnw;
                    end
                    OWN_DMA: begin
                        mem_addr_next  = dma_addr;
                        mem_wdata_next = dma_wdata;
                        acc_rnw_next   = dma_rnw;
                    end
                    default: begin
                        mem_addr_next  = '0;
                        mem_wdata_next = '0;
                        acc_rnw_next   = 1'b0;
                    end
                endcase

                if (grant != OWN_NONE) begin
                    state_next  = ACCESS;
                    owner_next  = grant;
                    cnt_next    = '0;
                    mem_oe_next = acc_rnw_next;
                    mem_we_next = ~acc_rnw_next;
                end else begin
                    mem_oe_next = 1'b0;
                    mem_we_next = 1'b0;
                end

                // Count only grants DMA actually lost; DMA going away forgives the debt.
                if (grant == OWN_DMA || !dma_req) begin
                    starve_next = '0;
                end else if (grant != OWN_NONE && starve_cnt != STARVE_MAX) begin
                    starve_next = starve_cnt + 4'd1;
                end
            end

            ACCESS: begin
                cnt_next = cnt + 4'd1;
                if (cnt == WE_OFF_CNT) begin
                    mem_we_next = 1'b0;
                end
                if (last_edge) begin
                    state_next  = IDLE;
                    owner_next  = OWN_NONE;
                    mem_oe_next = 1'b0;
                    mem_we_next = 1'b0;
                    case (owner)
                        OWN_VID: begin
                            vid_ack_next   = 1'b1;
                            vid_rdata_next = mem_rdata;
                        end
                        OWN_CPU: begin
                            cpu_done_next = 1'b1;
                            if (acc_rnw) begin
                                cpu_rdata_next = mem_rdata;
                            end
                        end
                        OWN_DMA: begin
                            dma_ack_next = 1'b1;
                            if (acc_rnw) begin
                                dma_rdata_next = mem_rdata;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset mid-access simply abandons it: strobes drop and no completion is reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            cnt         <= '0;
            starve_cnt  <= '0;
            acc_rnw     <= 1'b0;
            cpu_pend    <= 1'b0;
            cpu_rnw_l   <= 1'b0;
            cpu_addr_l  <= '0;
            cpu_wdata_l <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_oe      <= 1'b0;
            mem_we      <= 1'b0;
            cpu_rdata   <= '0;
            vid_rdata   <= '0;
            dma_rdata   <= '0;
            cpu_done    <= 1'b0;
            vid_ack     <= 1'b0;
            dma_ack     <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            cnt         <= cnt_next;
            starve_cnt  <= starve_next;
            acc_rnw     <= acc_rnw_next;
            cpu_pend    <= cpu_pend_next;
            cpu_rnw_l   <= cpu_rnw_l_next;
            cpu_addr_l  <= cpu_addr_l_next;
            cpu_wdata_l <= cpu_wdata_l_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
            mem_oe      <= mem_oe_next;
            mem_we      <= mem_we_next;
            cpu_rdata   <= cpu_rdata_next;
            vid_rdata   <= vid_rdata_next;
            dma_rdata   <= dma_rdata_next;
            cpu_done    <= cpu_done_next;
            vid_ack     <= vid_ack_next;
            dma_ack     <= dma_ack_next;
        end
    end

endmodule

// File: tb/tb_zmem_arbiter.sv
// Directed bench for zmem_arbiter: cycle tables for single CPU accesses,
// hand-written sequences for priority, starvation, reset abort and ack/strobe overlap.
module tb_zmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rnw;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done, cpu_wait;
    logic        vid_req;
    logic [19:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        dma_req, dma_rnw;
    logic [19:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_oe, mem_we;
    logic [15:0] mem_rdata;

    logic        use_model;
    logic [15:0] fixed_rdata;
    int          checks = 0;
    int          errors = 0;

    zmem_arbiter #(.AW(20), .DW(16), .ACC_CYC(4), .STARVE(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_wait(cpu_wait),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: either a fixed word or a word derived from the address.
    always_comb mem_rdata = use_model ? (mem_addr[15:0] ^ 16'h3C3C) : fixed_rdata;

    typedef struct {
        logic        req;
        logic        rnw;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata_in;
        logic        exp_oe;
        logic        exp_we;
        logic [19:0] exp_maddr;
        logic [15:0] exp_mwdata;
        logic        exp_done;
        logic        exp_wait;
        logic [15:0] exp_crdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic req, logic rnw, logic [19:0] addr, logic [15:0] wdata,
                                logic [15:0] rdata_in, logic oe, logic we, logic [19:0] maddr,
                                logic [15:0] mwdata, logic done, logic wt, logic [15:0] crdata);
        vec_t v;
        v.req = req; v.rnw = rnw; v.addr = addr; v.wdata = wdata; v.rdata_in = rdata_in;
        v.exp_oe = oe; v.exp_we = we; v.exp_maddr = maddr; v.exp_mwdata = mwdata;
        v.exp_done = done; v.exp_wait = wt; v.exp_crdata = crdata;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are applied 1ns after an edge; outputs are compared 1ns later in the same cycle.
    task automatic apply_stimulus(input int idx, input vec_t v);
        cpu_req     = v.req;
        cpu_rnw     = v.rnw;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wdata;
        fixed_rdata = v.rdata_in;
        #1;
        check_output($sformatf("vec%0d_oe", idx), 32'(mem_oe), 32'(v.exp_oe));
        check_output($sformatf("vec%0d_we", idx), 32'(mem_we), 32'(v.exp_we));
        check_output($sformatf("vec%0d_maddr", idx), 32'(mem_addr), 32'(v.exp_maddr));
        check_output($sformatf("vec%0d_mwdata", idx), 32'(mem_wdata), 32'(v.exp_mwdata));
        check_output($sformatf("vec%0d_done", idx), 32'(cpu_done), 32'(v.exp_done));
        check_output($sformatf("vec%0d_wait", idx), 32'(cpu_wait), 32'(v.exp_wait));
        check_output($sformatf("vec%0d_crdata", idx), 32'(cpu_rdata), 32'(v.exp_crdata));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        dma_req = 1'b0; dma_rnw = 1'b1; dma_addr = '0; dma_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int vid_cyc, cpu_cyc, dma_cyc;
        int vid_count, dma_seen, round1, round2;
        logic after_dma, next_known, next_was_vid;
        logic activity, found, glitch;
        int done_cyc;

        use_model   = 1'b0;
        fixed_rdata = '0;

        vecs[0]  = mk(1, 1, 20'h01234, 16'h0000, 16'hBEEF, 0, 0, 20'h00000, 16'h0000, 0, 1, 16'h0000);
        vecs[1]  = mk(0, 1, 20'h01234, 16'h0000, 16'hBEEF, 1, 0, 20'h01234, 16'h0000, 0, 1, 16'h0000);
        vecs[2]  = mk(0, 1, 20'h01234, 16'h0000, 16'hBEEF, 1, 0, 20'h01234, 16'h0000, 0, 1, 16'h0000);
        vecs[3]  = mk(0, 1, 20'h01234, 16'h0000, 16'hBEEF, 1, 0, 20'h01234, 16'h0000, 0, 1, 16'h0000);
        vecs[4]  = mk(0, 1, 20'h01234, 16'h0000, 16'hBEEF, 1, 0, 20'h01234, 16'h0000, 0, 1, 16'h0000);
        vecs[5]  = mk(0, 1, 20'h01234, 16'h0000, 16'hBEEF, 0, 0, 20'h01234, 16'h0000, 1, 0, 16'hBEEF);
        vecs[6]  = mk(0, 1, 20'h01234, 16'h0000, 16'h0000, 0, 0, 20'h00000, 16'h0000, 0, 0, 16'hBEEF);
        vecs[7]  = mk(1, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 0, 20'h00000, 16'h0000, 0, 1, 16'hBEEF);
        vecs[8]  = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 1, 20'h00010, 16'h5A5A, 0, 1, 16'hBEEF);
        vecs[9]  = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 1, 20'h00010, 16'h5A5A, 0, 1, 16'hBEEF);
        vecs[10] = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 1, 20'h00010, 16'h5A5A, 0, 1, 16'hBEEF);
        vecs[11] = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 0, 20'h00010, 16'h5A5A, 0, 1, 16'hBEEF);
        vecs[12] = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 0, 20'h00010, 16'h5A5A, 1, 0, 16'hBEEF);
        vecs[13] = mk(0, 0, 20'h00010, 16'h5A5A, 16'h1111, 0, 0, 20'h00000, 16'h0000, 0, 0, 16'hBEEF);

        reset_dut();
        #1;
        check_output("rst_outputs",
                     {27'(mem_addr | mem_wdata | cpu_rdata | vid_rdata | dma_rdata), mem_oe, mem_we,
                      cpu_done, vid_ack, dma_ack},
                     32'h0);
        check_output("rst_wait", 32'(cpu_wait), 32'h0);
        tick();

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Three simultaneous requesters: expect video, CPU, DMA acks 5 clocks apart.
        use_model = 1'b1;
        vid_req = 1'b1; vid_addr = 20'h0A000;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 20'h00200; cpu_wdata = '0;
        dma_req = 1'b1; dma_rnw = 1'b1; dma_addr = 20'h30300; dma_wdata = '0;
        #1;
        check_output("prio_wait_strobe", 32'(cpu_wait), 32'h1);
        vid_cyc = -1; cpu_cyc = -1; dma_cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                cpu_req = 1'b0;
                vid_req = 1'b0;
            end
            if (vid_ack && vid_cyc < 0) begin
                vid_cyc = i;
                check_output("prio_vid_rdata", 32'(vid_rdata), 32'(16'hA000 ^ 16'h3C3C));
            end
            if (cpu_done && cpu_cyc < 0) begin
                cpu_cyc = i;
                check_output("prio_cpu_rdata", 32'(cpu_rdata), 32'(16'h0200 ^ 16'h3C3C));
            end
            if (dma_ack && dma_cyc < 0) begin
                dma_cyc = i;
                dma_req = 1'b0;
                check_output("prio_dma_rdata", 32'(dma_rdata), 32'(16'h0300 ^ 16'h3C3C));
            end
        end
        check_output("prio_vid_cycle", 32'(vid_cyc), 32'd5);
        check_output("prio_cpu_cycle", 32'(cpu_cyc), 32'd10);
        check_output("prio_dma_cycle", 32'(dma_cyc), 32'd15);

        // Continuous video plus DMA: DMA forced after 15 video grants, twice in a row.
        reset_dut();
        vid_req = 1'b1; vid_addr = 20'h0C000;
        dma_req = 1'b1; dma_rnw = 1'b1; dma_addr = 20'h20D00;
        vid_count = 0; dma_seen = 0; round1 = -1; round2 = -1;
        after_dma = 1'b0; next_known = 1'b0; next_was_vid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (after_dma && !next_known && (vid_ack || dma_ack)) begin
                next_known   = 1'b1;
                next_was_vid = vid_ack;
            end
            if (vid_ack) vid_count++;
            if (dma_ack) begin
                dma_seen++;
                if (dma_seen == 1) begin
                    round1    = vid_count;
                    vid_count = 0;
                    after_dma = 1'b1;
                    check_output("starve_dma_rdata", 32'(dma_rdata), 32'(16'h0D00 ^ 16'h3C3C));
                end else begin
                    round2 = vid_count;
                    break;
                end
            end
        end
        vid_req = 1'b0;
        dma_req = 1'b0;
        check_output("starve_round1", 32'(round1), 32'd15);
        check_output("starve_round2", 32'(round2), 32'd15);
        check_output("starve_vid_resumes", 32'(next_was_vid), 32'h1);
        tick();

        // Reset in the second cycle of a DMA write aborts it, with a CPU request pending.
        dma_req = 1'b1; dma_rnw = 1'b0; dma_addr = 20'h40404; dma_wdata = 16'hC0DE;
        tick();
        check_output("abort_we_on", 32'(mem_we), 32'h1);
        check_output("abort_wdata", 32'(mem_wdata), 32'hC0DE);
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 20'h00333;
        tick();
        cpu_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_output("abort_wait_pend", 32'(cpu_wait), 32'h1);
        tick();
        rst_n   = 1'b1;
        dma_req = 1'b0;
        check_output("abort_we_off", 32'(mem_we), 32'h0);
        check_output("abort_wait_off", 32'(cpu_wait), 32'h0);
        check_output("abort_no_ack", 32'(dma_ack), 32'h0);
        activity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dma_ack || cpu_done || mem_oe || mem_we) activity = 1'b1;
        end
        check_output("abort_stays_idle", 32'(activity), 32'h0);

        // CPU strobe in the vid_ack cycle is granted at that edge with WAIT held throughout.
        vid_req = 1'b1; vid_addr = 20'h0B0B0;
        tick();
        vid_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vid_ack) begin
                found = 1'b1;
                break;
            end
        end
        check_output("overlap_vid_ack", 32'(found), 32'h1);
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 20'h00777;
        #1;
        check_output("overlap_wait_strobe", 32'(cpu_wait), 32'h1);
        tick();
        cpu_req = 1'b0;
        check_output("overlap_oe", 32'(mem_oe), 32'h1);
        check_output("overlap_addr", 32'(mem_addr), 32'h00777);
        glitch = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= 8; k++) begin
            if (cpu_done) begin
                done_cyc = k;
                break;
            end
            if (!cpu_wait) glitch = 1'b1;
            tick();
        end
        check_output("overlap_done_cycle", 32'(done_cyc), 32'd5);
        check_output("overlap_no_glitch", 32'(glitch), 32'h0);
        check_output("overlap_wait_release", 32'(cpu_wait), 32'h0);
        check_output("overlap_rdata", 32'(cpu_rdata), 32'(16'h0777 ^ 16'h3C3C));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
